risc16_mem_stage: RTL and testbench
===================================

# risc16_mem_stage

Memory-access stage of the RISC-16 pipeline. It sits between the execute stage (consumes `mem_task_t`) and register-file write-back (produces `wb_task_t`). It owns the 2^MEM_ADDR_WIDTH x MEM_DATA_WIDTH synchronous data RAM and performs SW writes and LW reads. It exports M1 hazard information so the decode-side hazard logic can detect load-use stalls.

## Interface
Parameters:
- MEM_DATA_WIDTH, 16, data RAM word width (= REG_DATA_WIDTH)
- MEM_ADDR_WIDTH, 8, data RAM address width; depth 2^MEM_ADDR_WIDTH
- REG_DATA_WIDTH, 16, register/ALU result width
- REG_ADDR_WIDTH, 3, register index width

Ports:
- clk_i  in  1  single clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- stall_i  in  1  global pipeline freeze
- mem_task_i  in  $bits(mem_task_t)  task from execute stage
- mem_task_valid_i  in  1  mem_task_i holds a real instruction
- mem_task_ready_o  in→out  1  stage accepts this cycle; = !stall_i
- wb_task_o  out  $bits(wb_task_t)  register-file write request
- fwd_m1_valid_o  out  1  M1 holds a register-writing instruction
- fwd_m1_reg_addr_o  out  REG_ADDR_WIDTH  destination of M1 instruction
- fwd_m1_load_o  out  1  M1 instruction is a load (result not yet available)

## Operation
- Accept = mem_task_valid_i & !stall_i. On accept edge:
  - RAM addr = mem_task_i.alu_res[MEM_ADDR_WIDTH-1:0]; upper bits ignored (aliasing, no fault).
  - If id_res.mem_wr_en: RAM[addr] <= id_res.mem_wr_data.
  - RAM read port enabled; read-first (a task with both write and load sees old data).
  - M1 register <= {valid=1, id_res, alu_res}.
- No accept and !stall_i: M1 valid <= 0.
- RAM read port not enabled when there is no accept, so its output holds under stall; no separate capture register.
- M1→output advance when !stall_i: out_valid <= M1 valid; wb_task_o.reg_addr <= wb_reg_addr; wr_data <= wb_mem_data_sel ? RAM q : alu_res.
- wb_task_o.wr_en = out_valid & out_wb_wr_en & !stall_i (combinational mask), so each instruction writes the register file exactly once.
- Stores (wb_wr_en=0) and NOPs flow through with wr_en=0.
- stall_i high: M1 and output registers and RAM hold; no RAM write, no accept.
- fwd_m1_valid_o = M1 valid & wb_wr_en; fwd_m1_load_o = fwd_m1_valid_o & wb_mem_data_sel; fwd_m1_reg_addr_o = M1 wb_reg_addr.

## Timing
- Reset (async assert, sync-safe deassert): M1 valid=0, out_valid=0, wb_task_o all zero, fwd_* = 0. RAM contents are not reset; they are undefined until written.
- Latency: a task accepted at edge N appears on wb_task_o during cycle N+2, plus one cycle per stalled cycle. The register write lands at the end of that cycle.
- Throughput: one task per cycle with no stalls.
- SW accepted at edge N is visible to an LW accepted at edge N+1 or later.
- Reset mid-operation: in-flight M1/output tasks are discarded with no wr_en. RAM writes already committed persist.
- stall_i asserted while out_valid: wr_en is 0 for the whole stall. It rises in the first cycle with stall_i=0 and data is unchanged.

## Test plan
- ALU op: task {alu_res=0x1234, wb_reg_addr=2, wb_wr_en=1, sel=0} at edge N → cycle N+2 wb_task_o = {0x1234, 2, wr_en=1}; N+3 wr_en=0.
- Store→load back-to-back: SW 0xBEEF @0x12 at N, LW r3 @0x12 at N+1 → cycle N+3 wr_data=0xBEEF, reg_addr=3, wr_en=1; SW cycle shows wr_en=0.
- Stall: LW r5 @0x40 (RAM=0xA5A5) accepted, stall_i high 3 cycles while in M1, with new addresses on mem_task_i → no wr_en during stall; exactly one wr_en pulse with 0xA5A5 after release; no accept during stall.
- Aliasing/read-first: SW 0x1111 @0x0112, then LW @0x0012 → 0x1111. Task with write 0x2222 and load at same address → returns 0x1111, RAM then holds 0x2222.
- Throughput/forwarding: 4 consecutive LWs r1..r4 → 4 consecutive wr_en cycles in order. fwd_m1_load_o=1 and fwd_m1_reg_addr_o tracks r1..r4 one cycle after each accept.
- Reset mid-flight: assert rst_i low with tasks in M1 and output → outputs zero immediately (async), no write after release, and previously stored RAM data remains readable.

Source files
------------

// File: rtl/risc16_mem_stage_if.sv
// risc16_mem_stage_if: task types plus the execute->memory task bus and the
// memory->write-back / hazard-forwarding outputs of the RISC-16 memory stage.
package risc16_mem_stage_pkg;
    localparam int RISC16_MEM_DATA_W = 16;
    localparam int RISC16_REG_DATA_W = 16;
    localparam int RISC16_REG_ADDR_W = 3;
    typedef struct packed {
        logic                         mem_wr_en;
        logic [RISC16_MEM_DATA_W-1:0] mem_wr_data;
        logic [RISC16_REG_ADDR_W-1:0] wb_reg_addr;
        logic                         wb_wr_en;
        logic                         wb_mem_data_sel;
    } id_res_t;
    typedef struct packed {
        id_res_t                      id_res;
        logic [RISC16_REG_DATA_W-1:0] alu_res;
    } mem_task_t;
    typedef struct packed {
        logic                         wr_en;
        logic [RISC16_REG_ADDR_W-1:0] reg_addr;
        logic [RISC16_REG_DATA_W-1:0] wr_data;
    } wb_task_t;
endpackage

interface risc16_mem_stage_if;
    import risc16_mem_stage_pkg::*;
    mem_task_t                    mem_task_i;
    logic                         mem_task_valid_i;
    logic                         mem_task_ready_o;
    wb_task_t                     wb_task_o;
    logic                         fwd_m1_valid_o;
    logic [RISC16_REG_ADDR_W-1:0] fwd_m1_reg_addr_o;
    logic                         fwd_m1_load_o;
    modport master (
        output mem_task_i, mem_task_valid_i,
        input  mem_task_ready_o, wb_task_o, fwd_m1_valid_o, fwd_m1_reg_addr_o, fwd_m1_load_o
    );
    modport slave (
        input  mem_task_i, mem_task_valid_i,
        output mem_task_ready_o, wb_task_o, fwd_m1_valid_o, fwd_m1_reg_addr_o, fwd_m1_load_o
    );
endinterface

// File: rtl/risc16_mem_stage.sv
// risc16_mem_stage: RISC-16 memory-access stage owning the synchronous data RAM;
// two register slots (M1, output) between execute and register-file write-back.
module risc16_mem_stage
    import risc16_mem_stage_pkg::*;
#(
    parameter int MEM_DATA_WIDTH = RISC16_MEM_DATA_W,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int REG_DATA_WIDTH = RISC16_REG_DATA_W,
    parameter int REG_ADDR_WIDTH = RISC16_REG_ADDR_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               stall_i,
    risc16_mem_stage_if.slave  bus
);
    logic                      accept;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] ram [2**MEM_ADDR_WIDTH];
    logic [MEM_DATA_WIDTH-1:0] ram_q;

    logic                      m1_valid_q, m1_valid_d;
    logic                      m1_we_q, m1_we_d;
    logic                      m1_sel_q, m1_sel_d;
    logic [REG_ADDR_WIDTH-1:0] m1_ra_q, m1_ra_d;
    logic [REG_DATA_WIDTH-1:0] m1_alu_q, m1_alu_d;

    logic                      out_valid_q, out_valid_d;
    logic                      out_we_q, out_we_d;
    logic [REG_ADDR_WIDTH-1:0] out_ra_q, out_ra_d;
    logic [REG_DATA_WIDTH-1:0] out_data_q, out_data_d;

    assign accept = bus.mem_task_valid_i & ~stall_i;
    assign addr   = bus.mem_task_i.alu_res[MEM_ADDR_WIDTH-1:0];

    // Read port only clocks on accept, so ram_q doubles as the load-data holding register.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            if (bus.mem_task_i.id_res.mem_wr_en) ram[addr] <= bus.mem_task_i.id_res.mem_wr_data;
            ram_q <= ram[addr];
        end
    end

    always_comb begin
        m1_valid_d  = stall_i ? m1_valid_q : accept;
        m1_we_d     = accept ? bus.mem_task_i.id_res.wb_wr_en : m1_we_q;
        m1_sel_d    = accept ? bus.mem_task_i.id_res.wb_mem_data_sel : m1_sel_q;
        m1_ra_d     = accept ? bus.mem_task_i.id_res.wb_reg_addr : m1_ra_q;
        m1_alu_d    = accept ? bus.mem_task_i.alu_res : m1_alu_q;
        out_valid_d = stall_i ? out_valid_q : m1_valid_q;
        out_we_d    = stall_i ? out_we_q : m1_we_q;
        out_ra_d    = stall_i ? out_ra_q : m1_ra_q;
        out_data_d  = stall_i ? out_data_q : (m1_sel_q ? ram_q : m1_alu_q);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m1_valid_q  <= 1'b0;
            m1_we_q     <= 1'b0;
            m1_sel_q    <= 1'b0;
            m1_ra_q     <= '0;
            m1_alu_q    <= '0;
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_ra_q    <= '0;
            out_data_q  <= '0;
        end else begin
            m1_valid_q  <= m1_valid_d;
            m1_we_q     <= m1_we_d;
            m1_sel_q    <= m1_sel_d;
            m1_ra_q     <= m1_ra_d;
            m1_alu_q    <= m1_alu_d;
            out_valid_q <= out_valid_d;
            out_we_q    <= out_we_d;
            out_ra_q    <= out_ra_d;
            out_data_q  <= out_data_d;
        end
    end

    // Masking with stall keeps a held instruction from writing the register file twice.
    assign bus.mem_task_ready_o   = ~stall_i;
    assign bus.wb_task_o.wr_en    = out_valid_q & out_we_q & ~stall_i;
    assign bus.wb_task_o.reg_addr = out_ra_q;
    assign bus.wb_task_o.wr_data  = out_data_q;
    assign bus.fwd_m1_valid_o     = m1_valid_q & m1_we_q;
    assign bus.fwd_m1_load_o      = m1_valid_q & m1_we_q & m1_sel_q;
    assign bus.fwd_m1_reg_addr_o  = m1_ra_q;
endmodule

// File: tb/tb_risc16_mem_stage.sv
// tb_risc16_mem_stage: directed plus randomized checks of the memory stage against
// a task-level model (results computed at accept time, delivered two advances later).
module tb_risc16_mem_stage;
    import risc16_mem_stage_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic stall_i = 1'b0;
    always #5 clk_i = ~clk_i;

    risc16_mem_stage_if bus();

    risc16_mem_stage dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (stall_i),
        .bus     (bus.slave)
    );

    typedef struct {
        bit          v;
        bit          we;
        bit          ld;
        logic [2:0]  ra;
        logic [15:0] d;
    } exp_t;

    exp_t        pipe[$];
    logic [15:0] mem [256];
    int          checks = 0;
    int          passed = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        exp_t z;
        z = '{default: 0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
    endtask

    task automatic drive(input bit v, input bit st, input bit mwe, input logic [15:0] mwd,
                         input logic [2:0] ra, input bit wwe, input bit sel, input logic [15:0] alu);
        stall_i = st;
        bus.mem_task_valid_i = v;
        bus.mem_task_i.id_res.mem_wr_en = mwe;
        bus.mem_task_i.id_res.mem_wr_data = mwd;
        bus.mem_task_i.id_res.wb_reg_addr = ra;
        bus.mem_task_i.id_res.wb_wr_en = wwe;
        bus.mem_task_i.id_res.wb_mem_data_sel = sel;
        bus.mem_task_i.alu_res = alu;
    endtask

    task automatic idle();
        drive(0, 0, 0, 16'h0, 3'd0, 0, 0, 16'h0);
    endtask

    // Check the current cycle against the model, then clock and let the model take the edge.
    task automatic step();
        exp_t r;
        logic [7:0] a;
        #1;
        chk("ready", bus.mem_task_ready_o, !stall_i);
        chk("wr_en", bus.wb_task_o.wr_en, pipe[0].v & pipe[0].we & !stall_i);
        if (pipe[0].v && pipe[0].we) begin
            chk("reg_addr", bus.wb_task_o.reg_addr, pipe[0].ra);
            chk("wr_data", bus.wb_task_o.wr_data, pipe[0].d);
        end
        chk("fwd_valid", bus.fwd_m1_valid_o, pipe[1].v & pipe[1].we);
        chk("fwd_load", bus.fwd_m1_load_o, pipe[1].v & pipe[1].we & pipe[1].ld);
        if (pipe[1].v && pipe[1].we) chk("fwd_reg", bus.fwd_m1_reg_addr_o, pipe[1].ra);
        @(posedge clk_i);
        if (!stall_i) begin
            r = '{default: 0};
            if (bus.mem_task_valid_i) begin
                a    = bus.mem_task_i.alu_res[7:0];
                r.v  = 1;
                r.we = bus.mem_task_i.id_res.wb_wr_en;
                r.ld = bus.mem_task_i.id_res.wb_mem_data_sel;
                r.ra = bus.mem_task_i.id_res.wb_reg_addr;
                r.d  = r.ld ? mem[a] : bus.mem_task_i.alu_res;
                if (bus.mem_task_i.id_res.mem_wr_en) mem[a] = bus.mem_task_i.id_res.mem_wr_data;
            end
            pipe.push_back(r);
            void'(pipe.pop_front());
        end
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wb"}, bus.wb_task_o, 0);
        chk({tag, "_fwd_valid"}, bus.fwd_m1_valid_o, 0);
        chk({tag, "_fwd_load"}, bus.fwd_m1_load_o, 0);
        chk({tag, "_fwd_reg"}, bus.fwd_m1_reg_addr_o, 0);
    endtask

    initial begin
        int kind;
        idle();
        clear_pipe();
        #2 rst_i = 1'b0;
        #1 reset_checks("rst0");
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Give every RAM word a known value.
        for (int i = 0; i < 256; i++) begin
            drive(1, 0, 1, 16'($urandom), 3'($urandom), 0, 0, {8'($urandom), 8'(i)});
            step();
        end

        // ALU result passes through with two-cycle latency and a single write pulse.
        drive(1, 0, 0, 16'h0, 3'd2, 1, 0, 16'h1234);
        step();
        idle();
        step();
        chk("alu_data", bus.wb_task_o.wr_data, 16'h1234);
        chk("alu_reg", bus.wb_task_o.reg_addr, 2);
        chk("alu_we", bus.wb_task_o.wr_en, 1);
        step();
        chk("alu_we_once", bus.wb_task_o.wr_en, 0);

        // Back-to-back store then load of the same word.
        drive(1, 0, 1, 16'hBEEF, 3'd0, 0, 0, 16'h0012);
        step();
        drive(1, 0, 0, 16'h0, 3'd3, 1, 1, 16'h0012);
        step();
        chk("sw_we", bus.wb_task_o.wr_en, 0);
        idle();
        step();
        chk("sl_data", bus.wb_task_o.wr_data, 16'hBEEF);
        chk("sl_reg", bus.wb_task_o.reg_addr, 3);
        chk("sl_we", bus.wb_task_o.wr_en, 1);

        // Stall with a load in M1 while the bus offers writes that must be ignored.
        drive(1, 0, 1, 16'hA5A5, 3'd0, 0, 0, 16'h0040);
        step();
        drive(1, 0, 0, 16'h0, 3'd5, 1, 1, 16'h0040);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 16'h5A5A, 3'd6, 1, 1, 16'h0040 + 16'(i));
            step();
            chk("stall_we", bus.wb_task_o.wr_en, 0);
        end
        idle();
        step();
        chk("stall_data", bus.wb_task_o.wr_data, 16'hA5A5);
        chk("stall_reg", bus.wb_task_o.reg_addr, 5);
        chk("stall_we_rel", bus.wb_task_o.wr_en, 1);
        step();
        chk("stall_we_once", bus.wb_task_o.wr_en, 0);
        drive(1, 0, 0, 16'h0, 3'd1, 1, 1, 16'h0040);
        step();
        idle();
        step();
        chk("stall_no_wr", bus.wb_task_o.wr_data, 16'hA5A5);

        // Address aliasing and read-first behaviour.
        drive(1, 0, 1, 16'h1111, 3'd0, 0, 0, 16'h0112);
        step();
        drive(1, 0, 0, 16'h0, 3'd4, 1, 1, 16'h0012);
        step();
        drive(1, 0, 1, 16'h2222, 3'd6, 1, 1, 16'hFF12);
        step();
        chk("alias_data", bus.wb_task_o.wr_data, 16'h1111);
        drive(1, 0, 0, 16'h0, 3'd7, 1, 1, 16'h0012);
        step();
        chk("rdfirst_data", bus.wb_task_o.wr_data, 16'h1111);
        chk("rdfirst_reg", bus.wb_task_o.reg_addr, 6);
        idle();
        step();
        chk("after_wr_data", bus.wb_task_o.wr_data, 16'h2222);

        // Four consecutive loads: full throughput and load forwarding info.
        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 0, 16'h0, 3'(i), 1, 1, 16'h0050 + 16'(i));
            step();
            chk("tp_fwd_load", bus.fwd_m1_load_o, 1);
            chk("tp_fwd_reg", bus.fwd_m1_reg_addr_o, i);
            if (i > 1) begin
                chk("tp_we", bus.wb_task_o.wr_en, 1);
                chk("tp_reg", bus.wb_task_o.reg_addr, i - 1);
            end
        end
        idle();
        step();
        chk("tp_we_last", bus.wb_task_o.wr_en, 1);
        chk("tp_reg_last", bus.wb_task_o.reg_addr, 4);

        // Reset with tasks in both M1 and the output slot.
        drive(1, 0, 0, 16'h0, 3'd2, 1, 1, 16'h0012);
        step();
        drive(1, 0, 0, 16'h0, 3'd3, 1, 0, 16'h7777);
        step();
        idle();
        #1 rst_i = 1'b0;
        #1 reset_checks("rst_mid");
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        clear_pipe();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_we", bus.wb_task_o.wr_en, 0);
        end
        drive(1, 0, 0, 16'h0, 3'd1, 1, 1, 16'h0012);
        step();
        idle();
        step();
        chk("rst_ram_kept", bus.wb_task_o.wr_data, 16'h2222);

        // Randomized mix of ALU ops, stores, loads and load+store with random stalls.
        for (int k = 0; k < 400; k++) begin
            kind = int'($urandom_range(0, 3));
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, kind == 1 || kind == 3,
                  16'($urandom), 3'($urandom), kind != 1, kind >= 2, 16'($urandom));
            step();
        end
        idle();
        step();
        step();
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
